// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multicycle control path: state encodings, opcode
// constants, ALU operation codes and mux-select constants. The ALU control and
// datapath blocks import this package as well.
package main_control_fsm_pkg;

    // Fixed state encodings; state_o exposes these values for debug.
    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StRExec    = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    // Opcodes (instruction[31:26]).
    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJump  = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    // ALUOp codes consumed by the ALU control block.
    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    // ALU operand B select.
    localparam logic [1:0] SrcBReg      = 2'b00;
    localparam logic [1:0] SrcBFour     = 2'b01;
    localparam logic [1:0] SrcBImm      = 2'b10;
    localparam logic [1:0] SrcBImmShift = 2'b11;

    // PC source select.
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

    // Bundle of all datapath control lines driven by the FSM.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // Loads and stores share the address-calculation path.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OpLw) || (op == OpSw);
    endfunction

endpackage

// File: rtl/main_control_fsm.sv
// Main control FSM for a classic multicycle datapath.
// Optional feature: define ADDI_EN to support addi (opcode 001000) via the
// ADDI_EXEC/ADDI_WB states; without it that opcode is reported as illegal.
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic        IRWrite,
    output logic        ALUSrcA,
    output logic        RegWrite,
    output logic        RegDst,
    output logic [1:0]  PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic        illegal_op,
    output logic [31:0] instr_count,
    output logic [3:0]  state_o
);

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_instr_count;
    logic [31:0] w_instr_count_d;
    logic        w_retire;
    logic        w_illegal;
    ctrl_t       w_ctrl;
    ctrl_t       w_ctrl_out;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus retire/illegal flags.
    always_comb begin
        w_state_next = r_state;
        w_retire     = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            StFetch: begin
                if (mem_ready) begin
                    w_state_next = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OpRType) begin
                    w_state_next = StRExec;
                end else if (is_mem_op(opcode)) begin
                    w_state_next = StMemAddr;
                end else if (opcode == OpBeq) begin
                    w_state_next = StBranch;
                end else if (opcode == OpJump) begin
                    w_state_next = StJump;
`ifdef ADDI_EN
                end else if (opcode == OpAddi) begin
                    w_state_next = StAddiExec;
`endif
                end else begin
                    w_state_next = StFetch;
                    w_illegal    = 1'b1;
                end
            end
            StMemAddr: begin
                w_state_next = (opcode == OpLw) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                if (mem_ready) begin
                    w_state_next = StMemWb;
                end
            end
            StMemWb: begin
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
            StMemWrite: begin
                if (mem_ready) begin
                    w_state_next = StFetch;
                    w_retire     = 1'b1;
                end
            end
            StRExec: begin
                w_state_next = StRWb;
            end
            StRWb: begin
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
            StBranch: begin
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
            StJump: begin
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
`ifdef ADDI_EN
            StAddiExec: begin
                w_state_next = StAddiWb;
            end
            StAddiWb: begin
                w_state_next = StFetch;
                w_retire     = 1'b1;
            end
`endif
            // Unused encodings (and the addi states when disabled) recover to FETCH.
            default: begin
                w_state_next = StFetch;
            end
        endcase
    end

    // Output decode: pure function of state, with mem_ready gating in FETCH.
    always_comb begin
        w_ctrl = '0;
        case (r_state)
            StFetch: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ior_d     = 1'b0;
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SrcBFour;
                w_ctrl.alu_op    = AluOpAdd;
                w_ctrl.pc_source = PcSrcAlu;
                // IR and PC only update once the fetched word is actually present.
                w_ctrl.ir_write  = mem_ready;
                w_ctrl.pc_write  = mem_ready;
            end
            StDecode: begin
                w_ctrl.alu_src_a = 1'b0;
                w_ctrl.alu_src_b = SrcBImmShift;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemAddr: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SrcBImm;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StMemRead: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ior_d    = 1'b1;
            end
            StMemWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_dst    = 1'b0;
            end
            StMemWrite: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.ior_d     = 1'b1;
            end
            StRExec: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SrcBReg;
                w_ctrl.alu_op    = AluOpFunct;
            end
            StRWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.mem_to_reg = 1'b0;
            end
            StBranch: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SrcBReg;
                w_ctrl.alu_op        = AluOpSub;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PcSrcAluOut;
            end
            StJump: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PcSrcJump;
            end
`ifdef ADDI_EN
            StAddiExec: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SrcBImm;
                w_ctrl.alu_op    = AluOpAdd;
            end
            StAddiWb: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b0;
                w_ctrl.mem_to_reg = 1'b0;
            end
`endif
            default: begin
                w_ctrl = '0;
            end
        endcase
    end

    // Retired-instruction counter, wraps naturally at 32 bits.
    assign w_instr_count_d = w_retire ? (r_instr_count + 32'd1) : r_instr_count;

    // Counter register, cleared asynchronously with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= 32'd0;
        end else begin
            r_instr_count <= w_instr_count_d;
        end
    end

    // Controls are held low while in reset so no PC/IR/register write can slip through.
    assign w_ctrl_out  = rst_n ? w_ctrl : '0;

    assign PCWrite     = w_ctrl_out.pc_write;
    assign PCWriteCond = w_ctrl_out.pc_write_cond;
    assign IorD        = w_ctrl_out.ior_d;
    assign MemRead     = w_ctrl_out.mem_read;
    assign MemWrite    = w_ctrl_out.mem_write;
    assign MemtoReg    = w_ctrl_out.mem_to_reg;
    assign IRWrite     = w_ctrl_out.ir_write;
    assign ALUSrcA     = w_ctrl_out.alu_src_a;
    assign RegWrite    = w_ctrl_out.reg_write;
    assign RegDst      = w_ctrl_out.reg_dst;
    assign PCSource    = w_ctrl_out.pc_source;
    assign ALUSrcB     = w_ctrl_out.alu_src_b;
    assign ALUOp       = w_ctrl_out.alu_op;
    assign illegal_op  = rst_n & w_illegal;
    assign instr_count = rst_n ? r_instr_count : 32'd0;
    assign state_o     = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// Self-checking bench for main_control_fsm: a behavioural model of the
// instruction flow checked every cycle, plus directed literal expectations.
module tb_main_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic        mem_ready = 1'b0;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic        illegal_op;
    logic [31:0] instr_count;
    logic [3:0]  state_o;

    int checks = 0;
    int errors = 0;

    main_control_fsm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .PCSource    (PCSource),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

`ifdef ADDI_EN
    localparam bit AddiEn = 1'b1;
`else
    localparam bit AddiEn = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    int          m_state = 0;
    logic [31:0] m_count = 32'd0;
    logic        load_req = 1'b0;

    function automatic bit legal_op(input logic [5:0] op);
        return op == 6'b000000 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010 || (AddiEn && op == 6'b001000);
    endfunction

    // Where an instruction goes next, following the phase rules.
    function automatic int next_of(input int st, input logic rdy, input logic [5:0] op);
        case (st)
            0:  return rdy ? 1 : 0;
            1: begin
                if (op == 6'b000000) return 6;
                if (op == 6'b100011 || op == 6'b101011) return 2;
                if (op == 6'b000100) return 8;
                if (op == 6'b000010) return 9;
                if (AddiEn && op == 6'b001000) return 10;
                return 0;
            end
            2:  return (op == 6'b100011) ? 3 : 5;
            3:  return rdy ? 4 : 3;
            5:  return rdy ? 0 : 5;
            6:  return 7;
            10: return AddiEn ? 11 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit retires(input int st, input logic rdy);
        return st == 4 || (st == 5 && rdy) || st == 7 || st == 8 || st == 9 ||
               (AddiEn && st == 11);
    endfunction

    // Expected control word:
    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,
    //  PCSource,ALUSrcB,ALUOp,illegal_op}
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill;
        logic [1:0] pcs, srcb, aop;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, ill} = '0;
        {pcs, srcb, aop} = '0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
            1:  begin srcb = 2'b11; ill = !legal_op(op); end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin srca = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: if (AddiEn) begin srca = 1; srcb = 2'b10; end
            11: if (AddiEn) rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rd, pcs, srcb, aop, ill};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_count <= 32'd0;
        end else begin
            m_state <= next_of(m_state, mem_ready, opcode);
            if (load_req) m_count <= 32'hFFFF_FFFF;
            else if (retires(m_state, mem_ready)) m_count <= m_count + 32'd1;
        end
    end

    logic [16:0] act_ctrl;
    assign act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                       ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rst_ctrl", {15'd0, act_ctrl}, 32'd0);
                check("rst_state", {28'd0, state_o}, 32'd0);
                check("rst_count", instr_count, 32'd0);
            end else begin
                check("model_ctrl", {15'd0, act_ctrl},
                      {15'd0, exp_ctrl(m_state, mem_ready, opcode)});
                check("model_state", {28'd0, state_o}, m_state);
                check("model_count", instr_count, load_req ? 32'hFFFF_FFFF : m_count);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int held;
        // Reset with mem_ready high: no PC/IR write may appear.
        mem_ready = 1'b1;
        #1;
        check("reset_state", {28'd0, state_o}, 32'd0);
        check("reset_irwrite", {31'd0, IRWrite}, 32'd0);
        check("reset_pcwrite", {31'd0, PCWrite}, 32'd0);
        check("reset_count", instr_count, 32'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        check("fetch_memread", {31'd0, MemRead}, 32'd1);
        check("fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        check("fetch_srcb", {30'd0, ALUSrcB}, 32'd1);

        // R-type: 0,1,6,7,0; opcode change in R_EXEC must be ignored.
        opcode = 6'b000000;
        cyc(); check("r_decode", {28'd0, state_o}, 32'd1);
        cyc(); check("r_exec", {28'd0, state_o}, 32'd6);
        check("r_aluop", {30'd0, ALUOp}, 32'd2);
        opcode = 6'b100011;
        cyc(); check("r_wb", {28'd0, state_o}, 32'd7);
        check("r_regdst", {31'd0, RegDst}, 32'd1);
        check("r_count_before", instr_count, 32'd0);
        cyc(); check("r_fetch", {28'd0, state_o}, 32'd0);
        check("r_count_after", instr_count, 32'd1);

        // lw with three stalled cycles in MEM_READ.
        opcode = 6'b100011;
        cyc(); cyc(); check("lw_memaddr", {28'd0, state_o}, 32'd2);
        mem_ready = 1'b0;
        cyc();
        held = 0;
        for (int i = 0; i < 4; i++) begin
            if (state_o == 4'd3 && MemRead && IorD) held++;
            if (i == 3) mem_ready = 1'b1;
            cyc();
        end
        check("lw_held_cycles", held, 32'd4);
        check("lw_memwb", {28'd0, state_o}, 32'd4);
        check("lw_wb_ctrl", {30'd0, RegWrite, MemtoReg}, 32'd3);
        cyc(); check("lw_count", instr_count, 32'd2);

        // sw with one stalled cycle in MEM_WRITE.
        opcode = 6'b101011;
        cyc(); cyc(); cyc();
        check("sw_memwrite", {28'd0, state_o}, 32'd5);
        check("sw_memwrite_sig", {31'd0, MemWrite}, 32'd1);
        mem_ready = 1'b0;
        cyc(); check("sw_hold", {28'd0, state_o}, 32'd5);
        check("sw_count_hold", instr_count, 32'd2);
        mem_ready = 1'b1;
        cyc(); check("sw_fetch", {28'd0, state_o}, 32'd0);
        check("sw_count", instr_count, 32'd3);

        // beq.
        opcode = 6'b000100;
        cyc(); cyc();
        check("beq_state", {28'd0, state_o}, 32'd8);
        check("beq_ctrl", {27'd0, ALUOp, PCWriteCond, PCSource}, {27'd0, 2'b01, 1'b1, 2'b01});
        cyc(); check("beq_count", instr_count, 32'd4);

        // Illegal opcode: one-cycle pulse, count unchanged.
        opcode = 6'b111111;
        cyc(); check("ill_pulse", {31'd0, illegal_op}, 32'd1);
        cyc(); check("ill_fetch", {28'd0, state_o}, 32'd0);
        check("ill_pulse_gone", {31'd0, illegal_op}, 32'd0);
        check("ill_count", instr_count, 32'd4);

        // addi: real path when enabled, illegal otherwise.
        opcode = 6'b001000;
        cyc();
`ifdef ADDI_EN
        check("addi_no_ill", {31'd0, illegal_op}, 32'd0);
        cyc(); check("addi_exec", {28'd0, state_o}, 32'd10);
        cyc(); check("addi_wb", {28'd0, state_o}, 32'd11);
        check("addi_regwrite", {31'd0, RegWrite}, 32'd1);
        cyc(); check("addi_count", instr_count, 32'd5);
`else
        check("addi_ill", {31'd0, illegal_op}, 32'd1);
        cyc(); check("addi_fetch", {28'd0, state_o}, 32'd0);
        check("addi_count", instr_count, 32'd4);
`endif

        // Reset dropped in the middle of a MEM_READ stall.
        opcode = 6'b100011;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc(); cyc();
        check("rst_mid_pre", {28'd0, state_o}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_state", {28'd0, state_o}, 32'd0);
        check("rst_mid_ctrl", {15'd0, act_ctrl}, 32'd0);
        check("rst_mid_count", instr_count, 32'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("post_rst_memread", {31'd0, MemRead}, 32'd1);

        // Counter wrap on a jump.
        force dut.r_instr_count = 32'hFFFF_FFFF;
        load_req = 1'b1;
        cyc();
        release dut.r_instr_count;
        load_req = 1'b0;
        #1;
        check("wrap_preload", instr_count, 32'hFFFF_FFFF);
        opcode = 6'b000010;
        mem_ready = 1'b1;
        cyc(); cyc();
        check("jump_state", {28'd0, state_o}, 32'd9);
        check("jump_pcsrc", {30'd0, PCSource}, 32'd2);
        check("jump_pcwrite", {31'd0, PCWrite}, 32'd1);
        cyc(); check("wrap_count", instr_count, 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
